// File: rtl/hilo_seq.sv
// hilo_seq: multi-cycle sequencer in front of the combinational multiplier and
// divider. It latches the operands, holds them for SETTLE_CYCLES, then captures
// the 64-bit result into the HI/LO register pair. It also services direct HI/LO
// writes from the bus.
//
// Optional feature, selected by the macro HILO_DIVZERO_TRAP_EN:
//   defined   - a divide with a zero divisor skips SETTLE, leaves HI/LO
//               untouched and raises div_zero together with done.
//   undefined - a zero divisor takes the normal path and div_zero is always 0.
module hilo_seq #(
    parameter int DATA_W        = 32,
    parameter int SETTLE_CYCLES = 4    // legal range 1..15
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                start,
    input  logic                op,
    input  logic [DATA_W-1:0]   opa,
    input  logic [DATA_W-1:0]   opb,
    output logic [DATA_W-1:0]   op_a_q,
    output logic [DATA_W-1:0]   op_b_q,
    input  logic [2*DATA_W-1:0] mul_res,
    input  logic [2*DATA_W-1:0] div_res,
    input  logic                hi_wr,
    input  logic                lo_wr,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   hi_out,
    output logic [DATA_W-1:0]   lo_out,
    output logic                busy,
    output logic                done,
    output logic                div_zero
);

`ifdef HILO_DIVZERO_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        WRITE  = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       op_q;        // 0 = multiply, 1 = divide
    logic       trap_q;      // current operation is a trapped divide-by-zero
    logic       div_zero_q;
    logic       trap_start;

    // A new request is a trap when the feature is built in and it divides by zero
    assign trap_start = TRAP_EN && op && (opb == '0);
    assign div_zero   = div_zero_q;

    // Sequencer, operand latches and HI/LO register pair
    // NOTE: every register here is updated with <= so all of them sample the
    // pre-edge values; a blocking = would let later statements see new values.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state      <= IDLE;
            cnt        <= '0;
            op_q       <= 1'b0;
            trap_q     <= 1'b0;
            div_zero_q <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            hi_out     <= '0;
            lo_out     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_wr) hi_out <= wdata;
                    if (lo_wr) lo_out <= wdata;
                    if (start) begin
                        op_a_q     <= opa;
                        op_b_q     <= opb;
                        op_q       <= op;
                        cnt        <= CNT_LOAD;
                        div_zero_q <= 1'b0;
                        busy       <= 1'b1;
                        trap_q     <= trap_start;
                        state      <= trap_start ? WRITE : SETTLE;
                    end
                end
                SETTLE: begin
                    if (hi_wr) hi_out <= wdata;
                    if (lo_wr) lo_out <= wdata;
                    if (cnt == 4'd0) begin
                        state <= WRITE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                WRITE: begin
                    // Result capture owns HI/LO this cycle; bus writes are dropped
                    if (trap_q) begin
                        div_zero_q <= 1'b1;
                    end else if (op_q) begin
                        hi_out <= div_res[2*DATA_W-1:DATA_W];
                        lo_out <= div_res[DATA_W-1:0];
                    end else begin
                        hi_out <= mul_res[2*DATA_W-1:DATA_W];
                        lo_out <= mul_res[DATA_W-1:0];
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_seq.sv
// Directed testbench for hilo_seq with default parameters. A behavioural
// multiplier and divider are attached to the latched operand outputs.
module tb_hilo_seq;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        start = 1'b0;
    logic        op    = 1'b0;
    logic [31:0] opa   = '0;
    logic [31:0] opb   = '0;
    logic [31:0] op_a_q, op_b_q;
    logic [63:0] mul_res, div_res;
    logic        hi_wr = 1'b0;
    logic        lo_wr = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] hi_out, lo_out;
    logic        busy, done, div_zero;

    int n_cmp = 0;
    int n_bad = 0;

    hilo_seq dut (
        .clock    (clock),
        .clear    (clear),
        .start    (start),
        .op       (op),
        .opa      (opa),
        .opb      (opb),
        .op_a_q   (op_a_q),
        .op_b_q   (op_b_q),
        .mul_res  (mul_res),
        .div_res  (div_res),
        .hi_wr    (hi_wr),
        .lo_wr    (lo_wr),
        .wdata    (wdata),
        .hi_out   (hi_out),
        .lo_out   (lo_out),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    always #5 clock = ~clock;

    // Combinational mul/div stage; a zero divisor yields a recognisable pattern
    assign mul_res = 64'(op_a_q) * 64'(op_b_q);
    always_comb begin
        div_res = 64'hAAAA_BBBB_CCCC_DDDD;
        if (op_b_q != 32'd0) div_res = {op_a_q % op_b_q, op_a_q / op_b_q};
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one cycle; outputs are sampled 1 ns after the rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present a request in cycle 0; returns in cycle 1
    task automatic launch(input logic o, input logic [31:0] a, input logic [31:0] b);
        op = o; opa = a; opb = b; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Step until done (bounded), checking latency and busy along the way
    task automatic wait_done(input string tag, input int cyc, input int exp_cyc);
        int  n = cyc;
        logic busy_low = 1'b0;
        while (!done && n < 20) begin
            if (!busy) busy_low = 1'b1;
            tick();
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(exp_cyc));
        check({tag, "_busy_while_running"}, 64'(busy_low), 64'd0);
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    endtask

    initial begin
        // Reset
        tick();
        tick();
        clear = 1'b0;
        check("rst_op_a", 64'(op_a_q), 64'd0);
        check("rst_op_b", 64'(op_b_q), 64'd0);
        check("rst_div_zero", 64'(div_zero), 64'd0);
        for (int i = 0; i < 10; i++) begin
            check("idle_quiet", {hi_out, lo_out, 30'd0, busy, done}, 64'd0);
            tick();
        end

        // Multiply 0x10000 * 0x10000
        launch(1'b0, 32'h0001_0000, 32'h0001_0000);
        check("mul_op_a_latched", 64'(op_a_q), 64'h0001_0000);
        wait_done("mul", 1, 6);
        check("mul_hi", 64'(hi_out), 64'h1);
        check("mul_lo", 64'(lo_out), 64'h0);
        tick();
        check("mul_done_one_cycle", 64'(done), 64'd0);

        // Divide 100 / 7 with an ignored start in cycle 3
        launch(1'b1, 32'd100, 32'd7);
        tick();
        tick();
        op = 1'b0; opa = 32'd50; opb = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        check("div_ignored_start_op_a", 64'(op_a_q), 64'd100);
        wait_done("div", 4, 6);
        check("div_hi_rem", 64'(hi_out), 64'd2);
        check("div_lo_quot", 64'(lo_out), 64'd14);

        // Start in the done cycle: multiply 3 * 5
        op = 1'b0; opa = 32'd3; opb = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        check("b2b_done_dropped", 64'(done), 64'd0);
        check("b2b_busy", 64'(busy), 64'd1);
        check("b2b_op_a", 64'(op_a_q), 64'd3);
        wait_done("b2b", 1, 6);
        check("b2b_hi", 64'(hi_out), 64'd0);
        check("b2b_lo", 64'(lo_out), 64'd15);
        tick();

        // Direct writes in IDLE
        hi_wr = 1'b1; wdata = 32'hDEAD_BEEF;
        tick();
        hi_wr = 1'b0;
        check("idle_hi_wr", 64'(hi_out), 64'hDEAD_BEEF);
        check("idle_hi_wr_lo_kept", 64'(lo_out), 64'd15);
        hi_wr = 1'b1; lo_wr = 1'b1; wdata = 32'h0BAD_F00D;
        tick();
        hi_wr = 1'b0; lo_wr = 1'b0;
        check("idle_both_wr", {hi_out, lo_out}, 64'h0BAD_F00D_0BAD_F00D);

        // Write in SETTLE honoured, write in WRITE dropped: 0xFFFFFFFF * 2
        launch(1'b0, 32'hFFFF_FFFF, 32'd2);
        tick();                                       // cycle 2
        lo_wr = 1'b1; wdata = 32'h0000_CAFE;
        tick();                                       // cycle 3
        lo_wr = 1'b0;
        check("settle_lo_wr", 64'(lo_out), 64'h0000_CAFE);
        tick();                                       // cycle 4
        tick();                                       // cycle 5 (WRITE)
        check("write_cycle_busy", 64'(busy), 64'd1);
        check("write_cycle_no_done", 64'(done), 64'd0);
        hi_wr = 1'b1; wdata = 32'hDEAD_BEEF;
        tick();                                       // cycle 6
        hi_wr = 1'b0;
        check("capture_done", 64'(done), 64'd1);
        check("capture_wins_hi", 64'(hi_out), 64'h1);
        check("capture_lo", 64'(lo_out), 64'hFFFF_FFFE);
        tick();

        // Divide by zero with HI/LO preloaded
        hi_wr = 1'b1; wdata = 32'h1111_1111;
        tick();
        hi_wr = 1'b0; lo_wr = 1'b1; wdata = 32'h2222_2222;
        tick();
        lo_wr = 1'b0;
        launch(1'b1, 32'd5, 32'd0);
`ifdef HILO_DIVZERO_TRAP_EN
        wait_done("dz", 1, 2);
        check("dz_flag", 64'(div_zero), 64'd1);
        check("dz_hi_kept", 64'(hi_out), 64'h1111_1111);
        check("dz_lo_kept", 64'(lo_out), 64'h2222_2222);
        tick();
        check("dz_flag_sticky", 64'(div_zero), 64'd1);
`else
        wait_done("dz", 1, 6);
        check("dz_flag", 64'(div_zero), 64'd0);
        check("dz_hi_pass", 64'(hi_out), 64'hAAAA_BBBB);
        check("dz_lo_pass", 64'(lo_out), 64'hCCCC_DDDD);
        tick();
        check("dz_flag_idle", 64'(div_zero), 64'd0);
`endif
        launch(1'b1, 32'd9, 32'd4);
        check("dz_cleared_on_start", 64'(div_zero), 64'd0);
        wait_done("div9", 1, 6);
        check("div9_result", {hi_out, lo_out}, 64'h0000_0001_0000_0002);
        tick();

        // Clear in cycle 3 of a multiply
        launch(1'b0, 32'd5, 32'd7);
        tick();
        tick();                                       // cycle 3
        clear = 1'b1;
        #1;
        check("clr_regs", {hi_out, lo_out}, 64'd0);
        check("clr_ops", {op_a_q, op_b_q}, 64'd0);
        check("clr_flags", {61'd0, busy, done, div_zero}, 64'd0);
        tick();
        clear = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("clr_no_done", {62'd0, busy, done}, 64'd0);
            tick();
        end
        check("clr_hi_lo_stay", {hi_out, lo_out}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
